// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the triggered ADC capture engine.
package adc_capture_pkg;

  localparam int SAMPLE_W         = 16;
  localparam int SAMPLES_PER_BEAT = 8;
  localparam int BEAT_W           = SAMPLE_W * SAMPLES_PER_BEAT;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DRAIN
  } state_t;

endpackage

// File: rtl/adc_capture_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// The head word is visible the cycle after it is written; the output reads zero while empty.
module adc_capture_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      occupancy
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign occupancy = count;
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; stale words are masked by the empty check above.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture_x8.sv
// Triggered capture of the 8-sample/clock ADC stream into a FIFO, replayed as one
// framed AXI4-Stream packet. A beat arriving while the FIFO is full aborts the capture.
module adc_capture_x8
  import adc_capture_pkg::*;
#(
  parameter int DWIDTH_IN  = BEAT_W,
  parameter int DWIDTH_OUT = BEAT_W,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DWIDTH_IN-1:0]  s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic [LEN_WIDTH-1:0]  capture_len,
  output logic                  busy,
  output logic                  overflow,
  output logic [DWIDTH_OUT-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  state_t               state;
  state_t               state_nxt;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic                 overflow_q;
  logic                 ready_q;

  logic [DWIDTH_IN-1:0] head_data;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [OCC_W-1:0]     occupancy;

  logic                 arm_ok;
  logic                 capture_beat;
  logic                 push;
  logic                 drop;
  logic                 pop;
  logic                 last_beat;

  // Fullness is taken before any same-cycle pop, so a draining consumer cannot rescue a beat.
  assign arm_ok       = (state == IDLE) & arm & (capture_len != '0);
  assign capture_beat = s_axis_tvalid & (((state == ARMED) & trigger) | (state == CAPTURE));
  assign push         = capture_beat & ~fifo_full;
  assign drop         = capture_beat & fifo_full;
  assign last_beat    = (beat_cnt == len_q - LEN_WIDTH'(1));
  assign pop          = m_axis_tvalid & m_axis_tready;

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = head_data;
  assign m_axis_tlast  = m_axis_tvalid & (state == DRAIN) & (occupancy == OCC_W'(1));
  assign busy          = (state != IDLE);
  assign overflow      = overflow_q;
  assign s_axis_tready = ready_q;

  adc_capture_fifo #(
    .WIDTH (DWIDTH_IN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push      (push),
    .push_data (s_axis_tdata),
    .pop       (pop),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .occupancy (occupancy)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ARMED and CAPTURE share the same exit rules; beat_cnt is zero in ARMED, so len=1 drains at once.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (arm_ok) begin
          state_nxt = ARMED;
        end
      end
      ARMED, CAPTURE: begin
        if (drop) begin
          state_nxt = DRAIN;
        end else if (push) begin
          state_nxt = last_beat ? DRAIN : CAPTURE;
        end
      end
      DRAIN: begin
        if (fifo_empty || (pop && m_axis_tlast)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      len_q      <= '0;
      beat_cnt   <= '0;
      overflow_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (arm_ok) begin
        len_q      <= capture_len;
        beat_cnt   <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        if (drop) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_x8.sv
// Randomised scoreboard bench for adc_capture_x8 with a queue-based capture model.
module tb_adc_capture_x8;

  localparam int DW    = 128;
  localparam int DEPTH = 16;
  localparam int LW    = 16;

  logic          aclk;
  logic          aresetn;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          arm;
  logic          trigger;
  logic [LW-1:0] capture_len;
  logic          busy;
  logic          overflow;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;

  adc_capture_x8 #(
    .DWIDTH_IN  (DW),
    .DWIDTH_OUT (DW),
    .FIFO_DEPTH (DEPTH),
    .LEN_WIDTH  (LW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .arm           (arm),
    .trigger       (trigger),
    .capture_len   (capture_len),
    .busy          (busy),
    .overflow      (overflow),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef enum int {M_IDLE, M_ARMED, M_CAP, M_DRAIN} mphase_t;

  mphase_t       phase;
  logic [DW-1:0] exp_data[$];
  bit            exp_last[$];
  int            taken;
  int            mlen;
  bit            ovf;
  bit            rdy;
  bit            popped;
  int            tests = 0;
  int            fails = 0;
  int            valid_pct = 100;
  int            ready_mode = 1;
  bit            tog;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ADC source and consumer ready, both randomised per cycle
  initial begin
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    tog = 1'b0;
    forever begin
      @(posedge aclk);
      #2;
      s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
      s_axis_tvalid = ($urandom_range(99) < valid_pct);
      case (ready_mode)
        0: m_axis_tready = 1'b0;
        1: m_axis_tready = 1'b1;
        2: begin tog = ~tog; m_axis_tready = tog; end
        default: m_axis_tready = ($urandom_range(1) == 1);
      endcase
    end
  end

  task take_beat(input int occ_before);
    if (occ_before >= DEPTH) begin
      ovf = 1'b1;
      phase = M_DRAIN;
      if (exp_last.size() > 0) exp_last[exp_last.size()-1] = 1'b1;
    end else begin
      exp_data.push_back(s_axis_tdata);
      exp_last.push_back(1'b0);
      taken++;
      if (taken == mlen) begin
        exp_last[exp_last.size()-1] = 1'b1;
        phase = M_DRAIN;
      end else begin
        phase = M_CAP;
      end
    end
  endtask

  // Reference model: captured beats are queued; occupancy before the edge includes any beat popped this cycle
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      exp_data.delete();
      exp_last.delete();
      phase = M_IDLE;
      ovf = 1'b0;
      rdy = 1'b0;
      taken = 0;
      mlen = 0;
      popped = 1'b0;
    end else begin
      int occ_before;
      occ_before = exp_data.size() + (popped ? 1 : 0);
      popped = 1'b0;
      rdy = 1'b1;
      case (phase)
        M_IDLE: if (arm && capture_len != 0) begin
          mlen = int'(capture_len);
          taken = 0;
          ovf = 1'b0;
          phase = M_ARMED;
        end
        M_ARMED: if (trigger && s_axis_tvalid) take_beat(occ_before);
        M_CAP:   if (s_axis_tvalid) take_beat(occ_before);
        default: if (exp_data.size() == 0) phase = M_IDLE;
      endcase
    end
  end

  // Monitor: compares every output mid-cycle and retires a beat on each handshake
  always @(negedge aclk) begin
    if (!aresetn) begin
      checkOutput("rst_s_tready", s_axis_tready, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_overflow", overflow, 0);
      checkOutput("rst_tvalid", m_axis_tvalid, 0);
      checkOutput("rst_tlast", m_axis_tlast, 0);
      checkOutput("rst_tdata", m_axis_tdata, 0);
    end else begin
      checkOutput("tvalid", m_axis_tvalid, exp_data.size() != 0);
      if (exp_data.size() != 0) begin
        checkOutput("tdata", m_axis_tdata, exp_data[0]);
        checkOutput("tlast", m_axis_tlast, exp_last[0]);
      end else begin
        checkOutput("tlast_idle", m_axis_tlast, 0);
      end
      checkOutput("busy", busy, phase != M_IDLE);
      checkOutput("overflow", overflow, ovf);
      checkOutput("s_tready", s_axis_tready, rdy);
      if (exp_data.size() != 0 && m_axis_tready) begin
        void'(exp_data.pop_front());
        void'(exp_last.pop_front());
        popped = 1'b1;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int c = 0;
    while ((phase != M_IDLE || busy) && c < budget) begin
      @(posedge aclk);
      #1;
      c++;
    end
    checkOutput("idle_timeout", c >= budget, 0);
  endtask

  task automatic wait_not_armed(input int budget);
    int c = 0;
    while (phase == M_ARMED && c < budget) begin
      @(posedge aclk);
      #1;
      c++;
    end
    checkOutput("trigger_timeout", c >= budget, 0);
  endtask

  task automatic arm_with(input int len);
    @(posedge aclk);
    #1;
    capture_len = LW'(len);
    arm = 1'b1;
    @(posedge aclk);
    #1;
    arm = 1'b0;
    capture_len = LW'($urandom);
  endtask

  task automatic applyStimulus(input int len, input int gap, input bit stray_arm, input int gate_cycles);
    int saved;
    arm_with(len);
    repeat (gap) begin
      @(posedge aclk);
      #1;
    end
    if (gate_cycles > 0) begin
      saved = valid_pct;
      valid_pct = 0;
      trigger = 1'b1;
      repeat (gate_cycles) @(posedge aclk);
      #1;
      valid_pct = saved;
    end else begin
      trigger = 1'b1;
    end
    wait_not_armed(500);
    trigger = 1'b0;
    if (stray_arm) begin
      capture_len = 3;
      arm = 1'b1;
      @(posedge aclk);
      #1;
      arm = 1'b0;
    end
    wait_idle(3000);
  endtask

  initial begin
    int c;
    aresetn = 1'b0;
    arm = 1'b0;
    trigger = 1'b0;
    capture_len = '0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    valid_pct = 100;
    ready_mode = 1;
    applyStimulus(4, 3, 1'b1, 0);
    applyStimulus(5, 1, 1'b0, 3);
    ready_mode = 2;
    applyStimulus(8, 2, 1'b0, 0);

    $display("[TB] overflow scenario");
    ready_mode = 0;
    arm_with(40);
    trigger = 1'b1;
    c = 0;
    while (phase != M_DRAIN && c < 200) begin
      @(posedge aclk);
      #1;
      c++;
    end
    trigger = 1'b0;
    checkOutput("ovf_timeout", c >= 200, 0);
    @(negedge aclk);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_busy", busy, 1);
    repeat (4) @(posedge aclk);
    #1;
    ready_mode = 1;
    wait_idle(500);

    arm_with(0);
    repeat (3) @(negedge aclk);
    checkOutput("len0_busy", busy, 0);
    checkOutput("len0_overflow_kept", overflow, 1);

    applyStimulus(1, 0, 1'b0, 0);

    $display("[TB] reset during capture");
    ready_mode = 0;
    arm_with(20);
    trigger = 1'b1;
    c = 0;
    while (exp_data.size() < 5 && c < 200) begin
      @(posedge aclk);
      #1;
      c++;
    end
    checkOutput("fill_timeout", c >= 200, 0);
    aresetn = 1'b0;
    trigger = 1'b0;
    #1;
    checkOutput("async_rst_tvalid", m_axis_tvalid, 0);
    checkOutput("async_rst_busy", busy, 0);
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    ready_mode = 1;
    applyStimulus(2, 1, 1'b0, 0);

    for (int i = 0; i < 12; i++) begin
      valid_pct = $urandom_range(30, 100);
      ready_mode = $urandom_range(1, 3);
      applyStimulus($urandom_range(1, 40), $urandom_range(0, 4), 1'b0, 0);
    end

    repeat (3) @(posedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
